cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-look-ahead adder/subtractor for the ALU datapath.

---
 rtl/cla_pipe_adder.sv | 195 +++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined 4-bit-group carry-look-ahead adder/subtractor with valid/ready stall.
// Optional build macro SATURATE_EN: saturate the sum on signed overflow when sat=1.
module cla_pipe_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int NG = WIDTH / 4;
  localparam int GPS = GROUPS_PER_STAGE;
  localparam int STAGES = (NG + GPS - 1) / GPS;

  localparam logic [WIDTH-1:0] MAX_POS =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  // 4-bit look-ahead group: {carry out, sum}
  function automatic logic [4:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g = x & y;
    p = x | y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], x ^ y ^ c[3:0]};
  endfunction

  // stage inputs (index k feeds stage k)
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  // stage results
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];

  // registers after each stage
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovfl;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] sum_q;
  logic             ovfl_q;
  logic             zero_q;
  logic             neg_q;
  logic             advance;

`ifdef SATURATE_EN
  logic st_sat [STAGES];
  logic r_sat  [STAGES];
`else
  logic sat_unused;
  assign sat_unused = sat;
`endif

  assign advance   = ~r_v[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = r_v[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign sum       = sum_q;
  assign ovfl      = ovfl_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

  // route ports into stage 0 and each register into the next stage
  always_comb begin
    st_a[0] = a;
    st_b[0] = b ^ {WIDTH{sub}};
    st_s[0] = '0;
    st_c[0] = sub;
    st_v[0] = in_valid;
`ifdef SATURATE_EN
    st_sat[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = r_a[k-1];
      st_b[k] = r_b[k-1];
      st_s[k] = r_s[k-1];
      st_c[k] = r_c[k-1];
      st_v[k] = r_v[k-1];
`ifdef SATURATE_EN
      st_sat[k] = r_sat[k-1];
`endif
    end
  end

  // resolve this stage's groups, rippling carry group to group
  always_comb begin
    logic [WIDTH-1:0] s_t;
    logic             c_t;
    int               gi;
    for (int k = 0; k < STAGES; k++) begin
      s_t = st_s[k];
      c_t = st_c[k];
      for (int g = 0; g < GPS; g++) begin
        gi = k * GPS + g;
        if (gi < NG) begin
          {c_t, s_t[gi*4 +: 4]} =
            cla4(st_a[k][gi*4 +: 4],
                 st_b[k][gi*4 +: 4], c_t);
        end
      end
      nx_s[k] = s_t;
      nx_c[k] = c_t;
    end
  end

  // final-stage flags and optional saturation
  always_comb begin
    a_msb    = st_a[STAGES-1][WIDTH-1];
    b_msb    = st_b[STAGES-1][WIDTH-1];
    fin_ovfl = (a_msb == b_msb) &
               (nx_s[STAGES-1][WIDTH-1] != a_msb);
    fin_sum  = nx_s[STAGES-1];
`ifdef SATURATE_EN
    if (st_sat[STAGES-1] & fin_ovfl) begin
      fin_sum = a_msb ? MAX_NEG : MAX_POS;
    end
`endif
  end

  // global-stall pipeline shift; all stages move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
`ifdef SATURATE_EN
        r_sat[k] <= 1'b0;
`endif
      end
      sum_q  <= '0;
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= st_a[k];
        r_b[k] <= st_b[k];
        r_s[k] <= nx_s[k];
        r_c[k] <= nx_c[k];
        r_v[k] <= st_v[k];
`ifdef SATURATE_EN
        r_sat[k] <= st_sat[k];
`endif
      end
      sum_q  <= fin_sum;
      ovfl_q <= fin_ovfl;
      zero_q <= (fin_sum == '0);
      neg_q  <= fin_sum[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=16, 2 stages).
// Saturation checks are included when SATURATE_EN is defined.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovfl;
  logic        zero;
  logic        neg;

  int errors = 0;
  int checks = 0;

  cla_pipe_adder #(
    .WIDTH(16),
    .GROUPS_PER_STAGE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .sub(sub),
    .sat(sat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovfl(ovfl),
    .zero(zero),
    .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_res(
    input string       tag,
    input logic [15:0] s,
    input logic        co,
    input logic        ov,
    input logic        z,
    input logic        n
  );
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"}, 32'(sum), 32'(s));
    chk({tag, ".cout"}, 32'(cout), 32'(co));
    chk({tag, ".ovfl"}, 32'(ovfl), 32'(ov));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".neg"}, 32'(neg), 32'(n));
  endtask

  task automatic drive(
    input logic [15:0] xa,
    input logic [15:0] xb,
    input logic        xs,
    input logic        xt
  );
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sub = xs;
    sat = xt;
  endtask

  // one op, then check latency: invalid after 1 edge
  task automatic issue(
    input string       tag,
    input logic [15:0] xa,
    input logic [15:0] xb,
    input logic        xs,
    input logic        xt
  );
    @(negedge clk);
    drive(xa, xb, xs, xt);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    sat = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.flags",
        32'({cout, ovfl, zero, neg}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    issue("t1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk_res("t1", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    issue("t2", 16'h0005, 16'h0005, 1'b1, 1'b0);
    chk_res("t2", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    issue("t3", 16'h8000, 16'h0001, 1'b1, 1'b0);
    chk_res("t3", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    issue("t4", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk_res("t4", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // sat=1 on a non-overflow op must not alter it
    issue("t4s", 16'h1234, 16'h1111, 1'b0, 1'b1);
    chk_res("t4s", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SATURATE_EN
    issue("t1s", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk_res("t1s", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("t3s", 16'h8000, 16'h0001, 1'b1, 1'b1);
    chk_res("t3s", 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    issue("t1w", 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk_res("t1w", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    // back-to-back: results on consecutive cycles
    @(negedge clk);
    chk("b2b.rdy0", 32'(in_ready), 32'd1);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.rdy1", 32'(in_ready), 32'd1);
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b.rdy2", 32'(in_ready), 32'd1);
    chk_res("b2b0", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h0100, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    chk("b2b.rdy3", 32'(in_ready), 32'd1);
    chk_res("b2b1", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_res("b2b2", 16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_res("b2b3", 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b.end", 32'(out_valid), 32'd0);

    // stall with a full pipe
    drive(16'h1000, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'h2000, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    chk_res("st0", 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(16'h3000, 16'h0003, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st.in_ready", 32'(in_ready), 32'd0);
      chk_res("st.hold", 16'h1001,
              1'b0, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk_res("st1", 16'h2002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_res("st2", 16'h2FFD, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("st.end", 32'(out_valid), 32'd0);

    // async reset with two ops in flight
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'h0202, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_res("rs.pre", 16'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs.valid", 32'(out_valid), 32'd0);
    chk("rs.sum", 32'(sum), 32'd0);
    chk("rs.flags",
        32'({cout, ovfl, zero, neg}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs.flush", 32'(out_valid), 32'd0);
    issue("rs.post", 16'h4321, 16'h1234, 1'b0, 1'b0);
    chk_res("rs.post", 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
